// File: rtl/mem_port_arbiter.sv
// Shares one DMEM port between the CPU MEM stage and a host; CPU wins until the host has waited MAX_WAIT cycles.
// Optional perf counters are built only when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [4:0]  cpu_ctl,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_valid,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [4:0]  host_ctl,
  output logic        host_ready,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [4:0]  mem_ctl,
  input  logic [31:0] mem_rdata,
  output logic [31:0] perf_host_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic [31:0] r_host_rdata;
  logic        w_accept;

  // rst masks acceptance so every combinational output falls back to a quiet CPU view
  assign w_accept = !rst && (r_state == IDLE) && host_valid &&
                    (!cpu_req || (r_wait_cnt == LP_MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 8'd0;
      r_host_rdata <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_accept && !host_we) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = 8'd0;
    if (r_state == IDLE) begin
      if (w_accept) begin
        w_state_nxt = RESP;
      end
    end else begin
      w_state_nxt = IDLE;
    end
    if (host_valid && !w_accept) begin
      w_wait_nxt = (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 8'd1;
    end
  end

  assign host_ready  = w_accept;
  assign cpu_stall   = w_accept && cpu_req;
  assign host_rvalid = (r_state == RESP) && !rst;
  assign host_rdata  = r_host_rdata;
  assign cpu_rdata   = mem_rdata;

  assign mem_addr  = w_accept ? host_addr  : cpu_addr;
  assign mem_wdata = w_accept ? host_wdata : cpu_wdata;
  assign mem_ctl   = w_accept ? host_ctl   : cpu_ctl;
  assign mem_we    = !rst && (w_accept ? host_we : (cpu_req && cpu_we));

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_perf_host_cnt;
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_host_cnt  <= 32'd0;
      r_perf_stall_cnt <= 32'd0;
    end else begin
      if (w_accept) begin
        r_perf_host_cnt <= r_perf_host_cnt + 32'd1;
      end
      if (cpu_stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_host_cnt  = r_perf_host_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`else
  assign perf_host_cnt  = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations (MAX_WAIT = 8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [4:0]  cpu_ctl;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_valid;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [4:0]  host_ctl;
  logic        host_ready;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [4:0]  mem_ctl;
  logic [31:0] mem_rdata;
  logic [31:0] perf_host_cnt;
  logic [31:0] perf_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ctl(cpu_ctl), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ctl(host_ctl), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ctl(mem_ctl),
    .mem_rdata(mem_rdata), .perf_host_cnt(perf_host_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_ctl = 0;
    host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_ctl = 0;
  endtask

  // 8 CPU-owned cycles, forced acceptance with stall, then RESP with CPU retry
  task automatic run_preempt(input logic we, input logic [31:0] rd, input logic [31:0] exp_rd);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hA5; cpu_ctl = 5'h03;
    host_valid = 1; host_we = we; host_addr = 32'h80; host_wdata = 32'h77; host_ctl = 5'h1C;
    mem_rdata = rd;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("pre_wait_ready", {31'd0, host_ready}, 32'd0);
      chk("pre_wait_stall", {31'd0, cpu_stall}, 32'd0);
      chk("pre_wait_addr", mem_addr, 32'h40);
      tick();
    end
    settle();
    chk("pre_acc_ready", {31'd0, host_ready}, 32'd1);
    chk("pre_acc_stall", {31'd0, cpu_stall}, 32'd1);
    chk("pre_acc_addr", mem_addr, 32'h80);
    chk("pre_acc_ctl", {27'd0, mem_ctl}, 32'h1C);
    chk("pre_acc_we", {31'd0, mem_we}, {31'd0, we});
    tick();
    host_valid = 0;
    mem_rdata = 32'h0BAD0BAD;
    settle();
    chk("pre_resp_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("pre_resp_stall", {31'd0, cpu_stall}, 32'd0);
    chk("pre_resp_cpu_we", {31'd0, mem_we}, 32'd1);
    chk("pre_resp_rdata", host_rdata, exp_rd);
    tick();
  endtask

  initial begin
    logic [31:0] exp_perf;
    idle_inputs();
    mem_rdata = 32'h0;
    rst = 1;
    host_valid = 1; cpu_req = 1; cpu_we = 1;
    tick();
    settle();
    chk("rst_ready", {31'd0, host_ready}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_perf_host", perf_host_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    tick();
    rst = 0;
    idle_inputs();
    tick();

    // single host read with idle CPU
    host_valid = 1; host_we = 0; host_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("rd_ready_c0", {31'd0, host_ready}, 32'd1);
    chk("rd_addr_c0", mem_addr, 32'h10);
    chk("rd_we_c0", {31'd0, mem_we}, 32'd0);
    chk("rd_stall_c0", {31'd0, cpu_stall}, 32'd0);
    tick();
    host_valid = 0; mem_rdata = 32'h12345678;
    settle();
    chk("rd_rvalid_c1", {31'd0, host_rvalid}, 32'd1);
    chk("rd_rdata_c1", host_rdata, 32'hDEADBEEF);
    chk("rd_ready_c1", {31'd0, host_ready}, 32'd0);
    tick();
    settle();
    chk("rd_rvalid_c2", {31'd0, host_rvalid}, 32'd0);
    chk("rd_rdata_hold", host_rdata, 32'hDEADBEEF);

    // back-to-back host writes: one access per two cycles
    host_valid = 1; host_we = 1; host_addr = 32'h30; host_wdata = 32'hABCD;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("b2b_ready", {31'd0, host_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b_rvalid", {31'd0, host_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("b2b_mem_we", {31'd0, mem_we}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    host_valid = 0;
    settle();
    chk("wr_rdata_hold", host_rdata, 32'hDEADBEEF);
    tick();

    // CPU store during RESP, then CPU wins contention below MAX_WAIT
    host_valid = 1; host_we = 0; host_addr = 32'h18; mem_rdata = 32'h5A5A5A5A;
    settle();
    chk("st_acc_ready", {31'd0, host_ready}, 32'd1);
    tick();
    host_addr = 32'h99;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
    settle();
    chk("st_resp_we", {31'd0, mem_we}, 32'd1);
    chk("st_resp_addr", mem_addr, 32'h20);
    chk("st_resp_wdata", mem_wdata, 32'h55);
    chk("st_resp_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st_resp_ready", {31'd0, host_ready}, 32'd0);
    chk("st_resp_rdata", host_rdata, 32'h5A5A5A5A);
    tick();
    settle();
    chk("cpu_wins_ready", {31'd0, host_ready}, 32'd0);
    chk("cpu_wins_stall", {31'd0, cpu_stall}, 32'd0);
    chk("cpu_wins_addr", mem_addr, 32'h20);
    tick();
    idle_inputs();
    tick();

    // reset during RESP aborts the response
    host_valid = 1; host_we = 0; host_addr = 32'h44; mem_rdata = 32'h11112222;
    settle();
    chk("abort_acc", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 0; rst = 1;
    settle();
    chk("abort_rvalid_rst", {31'd0, host_rvalid}, 32'd0);
    tick();
    rst = 0;
    settle();
    chk("abort_rvalid_after", {31'd0, host_rvalid}, 32'd0);
    chk("abort_rdata", host_rdata, 32'd0);
    tick();

    // reset in what would be the acceptance cycle of a host write
    host_valid = 1; host_we = 1; host_addr = 32'h48; rst = 1;
    settle();
    chk("rstwr_ready", {31'd0, host_ready}, 32'd0);
    chk("rstwr_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    rst = 0; host_valid = 0;
    settle();
    chk("rstwr_mem_we_next", {31'd0, mem_we}, 32'd0);
    chk("rstwr_rvalid_next", {31'd0, host_rvalid}, 32'd0);
    tick();

    // three forced preemptions; counters were cleared by the reset above
    run_preempt(1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
    run_preempt(1'b1, 32'h22223333, 32'hCAFEF00D);
    run_preempt(1'b0, 32'h600DD00D, 32'h600DD00D);
    settle();
`ifdef MEM_ARB_PERF_CNT_EN
    exp_perf = 32'd3;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_host", perf_host_cnt, exp_perf);
    chk("perf_stall", perf_stall_cnt, exp_perf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter MAX_WAIT, default 8, SHALL be the host wait cycles before forced preemption of the CPU; legal range 1..255.
REQ-002: Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003: Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-004: Ports cpu_req/cpu_we SHALL be inputs, 1 bit each: MEM-stage load/store request and write flag.
REQ-005: Ports cpu_addr/cpu_wdata SHALL be inputs, 32 bits each; cpu_ctl SHALL be an input, 5 bits (opaque byte-size/ld-st control).
REQ-006: Port cpu_rdata SHALL be an output, 32 bits; cpu_stall SHALL be an output, 1 bit (combinational pipeline freeze).
REQ-007: Ports host_valid/host_we SHALL be inputs, 1 bit each; host_addr/host_wdata SHALL be inputs, 32 bits each; host_ctl SHALL be an input, 5 bits.
REQ-008: Port host_ready SHALL be an output, 1 bit; host_rvalid SHALL be an output, 1 bit; host_rdata SHALL be an output, 32 bits.
REQ-009: Ports mem_addr/mem_wdata SHALL be outputs, 32 bits each; mem_we SHALL be an output, 1 bit; mem_ctl SHALL be an output, 5 bits; mem_rdata SHALL be an input, 32 bits (combinational DMEM read, write on clk edge).
REQ-010: Ports perf_host_cnt/perf_stall_cnt SHALL be outputs, 32 bits each.

Function
REQ-011: FSM SHALL have exactly two states: IDLE and RESP.
REQ-012: Host acceptance SHALL occur when state==IDLE && host_valid && (!cpu_req || wait_cnt==MAX_WAIT); host_ready SHALL be 1 combinationally in that cycle only.
REQ-013: In the acceptance cycle, mem_* SHALL be driven from host_*; the state SHALL go to RESP.
REQ-014: In every other cycle, mem_* SHALL be driven from cpu_*, with mem_we = cpu_req & cpu_we and cpu_rdata = mem_rdata.
REQ-015: cpu_stall SHALL be 1 exactly when acceptance occurs while cpu_req==1; CPU writes SHALL be suppressed that cycle and the CPU SHALL retry next cycle.
REQ-016: On a host read acceptance, mem_rdata SHALL be registered into host_rdata; host_rvalid SHALL pulse 1 for one cycle in RESP for reads and writes alike.
REQ-017: RESP SHALL last one cycle, then return to IDLE; host_ready SHALL be 0 in RESP; CPU SHALL own the memory in RESP; maximum host throughput is one access per 2 cycles.
REQ-018: wait_cnt (8 bits) SHALL increment, saturating at MAX_WAIT, each cycle host_valid==1 without acceptance; it SHALL clear on acceptance or when host_valid==0.
REQ-019: When cpu_req and host_valid are both 1 with wait_cnt<MAX_WAIT, the CPU SHALL win and cpu_stall SHALL be 0.
REQ-020: host_rdata SHALL hold its value until the next host read acceptance.

Reset
REQ-021: With rst=1: state SHALL be IDLE, wait_cnt 0, host_rvalid 0, host_rdata 0, counters 0, host_ready 0, cpu_stall 0, mem_we 0 in the same cycle.
REQ-022: Reset during RESP SHALL abort the response: host_rvalid SHALL be 0 in the cycle after reset is asserted.

Configuration
REQ-023: With macro MEM_ARB_PERF_CNT_EN defined, perf_host_cnt SHALL increment per host acceptance and perf_stall_cnt per cpu_stall cycle, both wrapping at 2^32.
REQ-024: Without MEM_ARB_PERF_CNT_EN, both perf outputs SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-025: cpu_req=0, host read addr 0x10, mem_rdata=0xDEADBEEF -> host_ready=1 in cycle 0; host_rvalid=1 and host_rdata=0xDEADBEEF in cycle 1; cpu_stall=0.
REQ-026: cpu_req held 1, host_valid held 1, MAX_WAIT=8 -> 8 CPU-owned cycles, then acceptance with cpu_stall=1 and mem_we=0 unless host_we=1.
REQ-027: host_valid held 1, cpu_req=0 -> host_ready pattern 1,0,1,0; host_rvalid pattern 0,1,0,1.
REQ-028: CPU store 0x55 to 0x20 in RESP -> mem_we=1, mem_addr=0x20, mem_wdata=0x55, cpu_stall=0.
REQ-029: rst=1 asserted in the acceptance cycle of a host write -> mem_we=0 and host_rvalid=0 next cycle.
REQ-030: MEM_ARB_PERF_CNT_EN defined, 3 forced preemptions -> perf_host_cnt=3 and perf_stall_cnt=3; macro undefined -> both 0.
